// File: rtl/irda_fir_pkg.sv
// Shared definitions for the FIR transmit path: flag codes, sequencer states,
// the 4PPM chip table and CRC-32 constants/helpers.
package irda_fir_pkg;

  typedef enum logic [1:0] {
    FIR_FLAG_NONE = 2'b00,
    FIR_FLAG_PA   = 2'b01,
    FIR_FLAG_STA  = 2'b10,
    FIR_FLAG_STO  = 2'b11
  } fir_flag_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PA   = 3'd1,
    ST_STA  = 3'd2,
    ST_DATA = 3'd3,
    ST_STO  = 3'd4,
    ST_DONE = 3'd5
  } tx_state_e;

  // Symbol for dibit d sits at [4*d +: 4]; bit 3 of a symbol is the first chip on air.
  localparam logic [15:0] PPM_TABLE = {4'b0001, 4'b0010, 4'b0100, 4'b1000};

  localparam logic [31:0] CRC32_POLY     = 32'h04C11DB7;
  localparam logic [31:0] CRC32_POLY_REF = 32'hEDB88320;  // bit-reversed CRC32_POLY
  localparam logic [31:0] CRC32_INIT     = 32'hFFFFFFFF;

  function automatic logic [3:0] ppm_symbol(input logic [1:0] dibit);
    return PPM_TABLE[{dibit, 2'b00} +: 4];
  endfunction

  // Whole byte as 16 chips, first chip on air in bit 15 (dibit [1:0] goes first).
  function automatic logic [15:0] ppm_encode_byte(input logic [7:0] b);
    return {ppm_symbol(b[1:0]), ppm_symbol(b[3:2]), ppm_symbol(b[5:4]), ppm_symbol(b[7:6])};
  endfunction

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REF) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/irda_fir_4ppm_enc.sv
// 4PPM byte encoder: loads a byte, shifts out 16 chips one per advance and
// flags the byte boundary (chip counter at zero).
import irda_fir_pkg::*;

module irda_fir_4ppm_enc (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       adv,
  input  logic       load,
  input  logic [7:0] byte_i,
  output logic       chip_o,
  output logic       boundary_o
);

  logic [15:0] sr_q, sr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] enc;

  always_comb begin
    enc    = ppm_encode_byte(byte_i);
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    // The chip presented on a loading advance is the first chip of the new byte.
    chip_o = load ? enc[15] : sr_q[15];
    if (clr) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (adv) begin
      sr_d  = load ? {enc[14:0], 1'b0} : {sr_q[14:0], 1'b0};
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign boundary_o = (cnt_q == 4'd0);

endmodule

// File: rtl/irda_fir_tx_seq.sv
// FIR 4 Mb/s transmit frame sequencer: PA x PA_REPS, STA, 4PPM payload, STO.
// Optional CRC-32 trailer enabled by defining IRDA_FIR_TX_CRC_EN.
import irda_fir_pkg::*;

module irda_fir_tx_seq #(
  parameter int PA_REPS  = 16,
  parameter int PA_CNT_W = 8
) (
  input  logic       clk,
  input  logic       wb_rst_i,
  input  logic       fir_tx4_enable,
  input  logic       fir_tx8_enable,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  input  logic       tx_data_last,
  output logic       tx_data_ready,
  output logic       fir_gen_start,
  output logic [1:0] fir_flag,
  input  logic       flag_eof,
  input  logic       flag_gen_i,
  output logic       fir_tx_o,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_underrun
);

  localparam logic [PA_CNT_W-1:0] PA_LAST = PA_CNT_W'(PA_REPS - 1);

  tx_state_e             state_q, state_d;
  logic [PA_CNT_W-1:0]   pa_cnt_q, pa_cnt_d;
  logic                  gen_start_q, gen_start_d;
  logic                  acc_q, acc_d;
  logic                  armed_q, armed_d;
  logic                  done_q, done_d;
  logic                  last_q, last_d;
  logic                  ur_q, ur_d;
  logic                  underrun_q, underrun_d;
  logic                  fir_tx_q, fir_tx_d;

  logic                  is_flag, flag_fin;
  logic                  enc_load, enc_adv, enc_clr, enc_chip, enc_boundary;
  logic [7:0]            enc_byte;
  logic                  data_end, data_ur;

`ifdef IRDA_FIR_TX_CRC_EN
  logic [31:0]           crc_q, crc_d;
  logic                  crc_ph_q, crc_ph_d;
  logic [2:0]            crc_idx_q, crc_idx_d;
`endif

  irda_fir_4ppm_enc u_enc (
    .clk        (clk),
    .rst        (wb_rst_i),
    .clr        (enc_clr),
    .adv        (enc_adv),
    .load       (enc_load),
    .byte_i     (enc_byte),
    .chip_o     (enc_chip),
    .boundary_o (enc_boundary)
  );

  // Byte-boundary decision: next payload byte, CRC byte, or close the frame.
  always_comb begin
    enc_load      = 1'b0;
    enc_byte      = tx_data;
    tx_data_ready = 1'b0;
    data_end      = 1'b0;
    data_ur       = 1'b0;
    enc_clr       = (state_q != ST_DATA);
    if (state_q == ST_DATA && fir_tx8_enable && enc_boundary) begin
`ifdef IRDA_FIR_TX_CRC_EN
      if (crc_ph_q) begin
        if (crc_idx_q == 3'd4) begin
          data_end = 1'b1;
        end else begin
          enc_load = 1'b1;
          enc_byte = crc_q[7:0];
        end
      end else if (last_q) begin
        enc_load = 1'b1;
        enc_byte = ~crc_q[7:0];
      end
`else
      if (last_q) begin
        data_end = 1'b1;
      end
`endif
      else if (tx_data_valid) begin
        enc_load      = 1'b1;
        tx_data_ready = 1'b1;
      end else begin
        data_end = 1'b1;
        data_ur  = 1'b1;
      end
    end
    enc_adv = (state_q == ST_DATA) && fir_tx8_enable && (!enc_boundary || enc_load);
  end

  always_comb begin
    state_d     = state_q;
    pa_cnt_d    = pa_cnt_q;
    gen_start_d = gen_start_q;
    acc_d       = acc_q;
    armed_d     = armed_q;
    done_d      = done_q;
    last_d      = last_q;
    ur_d        = ur_q;
    underrun_d  = 1'b0;
    fir_tx_d    = fir_tx_q;

    // Flag handshake: accept on tx4, arm on eof low (drops a stale eof),
    // latch eof high, then move on at the next tx4.
    is_flag  = (state_q == ST_PA) || (state_q == ST_STA) || (state_q == ST_STO);
    flag_fin = is_flag && done_q && fir_tx4_enable;
    if (is_flag) begin
      if (gen_start_q && fir_tx4_enable) begin
        gen_start_d = 1'b0;
        acc_d       = 1'b1;
      end
      if (acc_q && !armed_q && !flag_eof) armed_d = 1'b1;
      if (armed_q && flag_eof)            done_d  = 1'b1;
      if (flag_fin) begin
        acc_d   = 1'b0;
        armed_d = 1'b0;
        done_d  = 1'b0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        fir_tx_d = 1'b0;
        if (tx_start) begin
          state_d     = ST_PA;
          pa_cnt_d    = '0;
          gen_start_d = 1'b1;
          last_d      = 1'b0;
          ur_d        = 1'b0;
        end
      end
      ST_PA: begin
        fir_tx_d = flag_gen_i;
        if (flag_fin) begin
          pa_cnt_d    = pa_cnt_q + PA_CNT_W'(1);
          gen_start_d = 1'b1;
          if (pa_cnt_q == PA_LAST) state_d = ST_STA;
        end
      end
      ST_STA: begin
        fir_tx_d = flag_gen_i;
        if (flag_fin) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (enc_adv) fir_tx_d = enc_chip;
        if (tx_data_ready) last_d = tx_data_last;
        if (data_end) begin
          state_d     = ST_STO;
          gen_start_d = 1'b1;
          if (data_ur) begin
            ur_d       = 1'b1;
            underrun_d = 1'b1;
          end
        end
      end
      ST_STO: begin
        fir_tx_d = flag_gen_i;
        if (flag_fin) state_d = ST_DONE;
      end
      ST_DONE: begin
        fir_tx_d = 1'b0;
        state_d  = ST_IDLE;
      end
      default: begin
        fir_tx_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      pa_cnt_q    <= '0;
      gen_start_q <= 1'b0;
      acc_q       <= 1'b0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
      last_q      <= 1'b0;
      ur_q        <= 1'b0;
      underrun_q  <= 1'b0;
      fir_tx_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pa_cnt_q    <= pa_cnt_d;
      gen_start_q <= gen_start_d;
      acc_q       <= acc_d;
      armed_q     <= armed_d;
      done_q      <= done_d;
      last_q      <= last_d;
      ur_q        <= ur_d;
      underrun_q  <= underrun_d;
      fir_tx_q    <= fir_tx_d;
    end
  end

`ifdef IRDA_FIR_TX_CRC_EN
  // CRC accumulates over payload; afterwards crc_q holds the remaining
  // complemented trailer bytes, sent low byte first.
  always_comb begin
    crc_d     = crc_q;
    crc_ph_d  = crc_ph_q;
    crc_idx_d = crc_idx_q;
    if (state_q == ST_IDLE && tx_start) begin
      crc_d     = CRC32_INIT;
      crc_ph_d  = 1'b0;
      crc_idx_d = '0;
    end else if (tx_data_ready) begin
      crc_d = crc32_byte(crc_q, tx_data);
    end else if (enc_load && !crc_ph_q) begin
      crc_d     = {8'h00, ~crc_q[31:8]};
      crc_ph_d  = 1'b1;
      crc_idx_d = 3'd1;
    end else if (enc_load) begin
      crc_d     = {8'h00, crc_q[31:8]};
      crc_idx_d = crc_idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      crc_q     <= '0;
      crc_ph_q  <= 1'b0;
      crc_idx_q <= '0;
    end else begin
      crc_q     <= crc_d;
      crc_ph_q  <= crc_ph_d;
      crc_idx_q <= crc_idx_d;
    end
  end
`endif

  always_comb begin
    case (state_q)
      ST_PA:   fir_flag = FIR_FLAG_PA;
      ST_STA:  fir_flag = FIR_FLAG_STA;
      ST_STO:  fir_flag = FIR_FLAG_STO;
      default: fir_flag = FIR_FLAG_NONE;
    endcase
  end

  assign fir_gen_start = gen_start_q;
  assign fir_tx_o      = fir_tx_q;
  assign tx_busy       = (state_q != ST_IDLE);
  assign tx_done       = (state_q == ST_DONE) && !ur_q;
  assign tx_underrun   = underrun_q;

endmodule

// File: tb/tb_irda_fir_tx_seq.sv
// Bench for irda_fir_tx_seq: flag-generator model, payload driver and a
// chip/flag scoreboard derived from the frame format.
module tb_irda_fir_tx_seq;

  localparam int PA_REPS = 16;

  logic       clk = 1'b0;
  logic       wb_rst_i, fir_tx4_enable, fir_tx8_enable, tx_start;
  logic [7:0] tx_data;
  logic       tx_data_valid, tx_data_last, flag_eof, flag_gen_i;
  logic       tx_data_ready, fir_gen_start, fir_tx_o, tx_busy, tx_done, tx_underrun;
  logic [1:0] fir_flag;

  irda_fir_tx_seq #(.PA_REPS(PA_REPS), .PA_CNT_W(8)) dut (
    .clk            (clk),
    .wb_rst_i       (wb_rst_i),
    .fir_tx4_enable (fir_tx4_enable),
    .fir_tx8_enable (fir_tx8_enable),
    .tx_start       (tx_start),
    .tx_data        (tx_data),
    .tx_data_valid  (tx_data_valid),
    .tx_data_last   (tx_data_last),
    .tx_data_ready  (tx_data_ready),
    .fir_gen_start  (fir_gen_start),
    .fir_flag       (fir_flag),
    .flag_eof       (flag_eof),
    .flag_gen_i     (flag_gen_i),
    .fir_tx_o       (fir_tx_o),
    .tx_busy        (tx_busy),
    .tx_done        (tx_done),
    .tx_underrun    (tx_underrun)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- scoreboard state ----------------
  logic [0:0] exp_q[$];
  logic [0:0] got_chips[$];
  logic [1:0] got_flags[$];
  logic [7:0] payload[$];

  int cyc = 0;
  int tx4_phase = 0;
  int pay_idx, ur_lim;
  int gen_phase = 0, gen_cnt = 0;
  logic acc_pend = 1'b0;
  int ready_cnt, done_cnt, ur_cnt, done_cyc;
  logic sta_seen, sto_seen, skip_first;
  logic [1:0] prev_flag;
  logic prev_gen, prev_busy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic push_byte_chips(input logic [7:0] b);
    int sym;
    for (int d = 0; d < 4; d++) begin
      sym = (int'(b) >> (2 * d)) & 3;
      for (int p = 0; p < 4; p++) exp_q.push_back(1'(p == sym));
    end
  endtask

  function automatic logic [31:0] ref_crc(input int n);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ payload[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    return ~c;
  endfunction

  // ---------------- driver: one clock of stimulus + pre-edge sampling ----------------
  task automatic step(input logic start);
    @(negedge clk);
    cyc++;
    fir_tx8_enable = (cyc % 4 == 0);
    fir_tx4_enable = (cyc % 8 == tx4_phase);
    tx_start       = start;
    if (acc_pend) begin
      gen_phase = 1;
      gen_cnt   = $urandom_range(0, 3);
      acc_pend  = 1'b0;
    end
    case (gen_phase)
      1: if (gen_cnt == 0) begin
           gen_phase = 2;
           gen_cnt   = $urandom_range(4, 24);
           flag_eof  = 1'b0;
         end else gen_cnt--;
      2: if (gen_cnt == 0) begin
           gen_phase = 0;
           flag_eof  = 1'b1;
         end else gen_cnt--;
      default: ;
    endcase
    flag_gen_i    = 1'($urandom_range(0, 1));
    tx_data_valid = (pay_idx < ur_lim);
    tx_data       = (pay_idx < payload.size()) ? payload[pay_idx] : 8'($urandom);
    tx_data_last  = (pay_idx == payload.size() - 1);
    #4;
    if (fir_gen_start && fir_tx4_enable) begin
      check_eq("flag_req_gen_idle", gen_phase, 0);
      got_flags.push_back(fir_flag);
      acc_pend = 1'b1;
    end
    if (tx_data_ready) begin
      check_eq("ready_qual", {fir_tx8_enable, tx_data_valid}, 2'b11);
      ready_cnt++;
      pay_idx++;
    end
    if (tx_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (tx_underrun) ur_cnt++;
    if (fir_flag == 2'b10) sta_seen = 1'b1;
    if (fir_flag == 2'b11) sto_seen = 1'b1;
    if (tx_busy && fir_flag == 2'b00 && sta_seen && !sto_seen && fir_tx8_enable) begin
      if (skip_first) skip_first = 1'b0;
      else got_chips.push_back(fir_tx_o);
    end
    if (prev_flag != 2'b00 && fir_flag != 2'b00) check_eq("flag_chip", fir_tx_o, prev_gen);
    if (!prev_busy && !tx_busy) check_eq("idle_chip", fir_tx_o, 0);
    prev_flag = fir_flag;
    prev_gen  = flag_gen_i;
    prev_busy = tx_busy;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"},  tx_busy, 0);
    check_eq({tag, "_txo"},   fir_tx_o, 0);
    check_eq({tag, "_start"}, fir_gen_start, 0);
    check_eq({tag, "_flag"},  fir_flag, 0);
    check_eq({tag, "_ready"}, tx_data_ready, 0);
    check_eq({tag, "_done"},  {tx_done, tx_underrun}, 0);
  endtask

  // Runs one frame; ur_at < payload size drops valid from that byte on.
  // abort_chips > 0 applies reset once that many data chips have gone out.
  task automatic run_frame(input int ur_at, input int abort_chips);
    int  n, sent, budget;
    logic underrun;
    n = payload.size();
    ur_lim = (ur_at >= 0 && ur_at < n) ? ur_at : n;
    underrun = (ur_lim < n);
    exp_q.delete(); got_chips.delete(); got_flags.delete();
    pay_idx = 0; ready_cnt = 0; done_cnt = 0; ur_cnt = 0; done_cyc = 0;
    sta_seen = 0; sto_seen = 0; skip_first = 1; prev_flag = 0; prev_busy = 0; prev_gen = 0;
    step(1'b1);
    budget = 0;
    while (!(prev_busy == 1'b0 && budget > 2) && budget < 20000) begin
      if (abort_chips > 0 && got_chips.size() >= abort_chips) begin
        @(negedge clk);
        wb_rst_i = 1'b1;
        #1;
        check_reset_outputs("abort_now");
        @(negedge clk);
        #4;
        check_reset_outputs("abort_next");
        wb_rst_i  = 1'b0;
        gen_phase = 0;
        acc_pend  = 1'b0;
        flag_eof  = 1'b1;
        return;
      end
      step(1'b0);
      budget++;
    end
    check_eq("frame_timeout", tx_busy, 0);
    sent = ur_lim;
    for (int i = 0; i < sent; i++) push_byte_chips(payload[i]);
`ifdef IRDA_FIR_TX_CRC_EN
    if (!underrun) begin
      logic [31:0] crc;
      crc = ref_crc(n);
      for (int i = 0; i < 4; i++) push_byte_chips(crc[8*i +: 8]);
    end
`endif
    check_eq("ready_count", ready_cnt, sent);
    check_eq("done_count", done_cnt, underrun ? 0 : 1);
    check_eq("underrun_count", ur_cnt, underrun ? 1 : 0);
    if (!underrun) check_eq("busy_falls_after_done", cyc - done_cyc, 1);
    check_eq("flag_count", got_flags.size(), PA_REPS + 2);
    for (int i = 0; i < got_flags.size(); i++)
      check_eq($sformatf("flag_seq[%0d]", i), got_flags[i],
               (i < PA_REPS) ? 2'b01 : (i == PA_REPS) ? 2'b10 : 2'b11);
    check_eq("chip_count", got_chips.size(), exp_q.size());
    for (int i = 0; i < got_chips.size() && i < exp_q.size(); i++)
      check_eq($sformatf("chip[%0d]", i), got_chips[i], exp_q[i]);
    repeat (3) step(1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    wb_rst_i = 1'b1; fir_tx4_enable = 0; fir_tx8_enable = 0; tx_start = 0;
    tx_data = 0; tx_data_valid = 0; tx_data_last = 0; flag_eof = 1'b1; flag_gen_i = 0;
    repeat (3) @(negedge clk);
    #4;
    check_reset_outputs("reset");
    @(negedge clk);
    wb_rst_i = 1'b0;

    tx4_phase = 0; payload = '{8'h1B};
    run_frame(-1, 0);

    tx4_phase = 2; payload = '{8'h00, 8'hFF, 8'hA5};
    run_frame(-1, 0);

    tx4_phase = 0; payload = '{8'h3C, 8'h5A, 8'h77};
    run_frame(1, 0);

    tx4_phase = 2; payload = '{8'h12, 8'h34, 8'h56, 8'h78};
    run_frame(-1, 6);
    payload = '{8'hC3, 8'h81, 8'h7E};
    run_frame(-1, 0);

    for (int f = 0; f < 3; f++) begin
      int len;
      tx4_phase = (f % 2) * 2;
      len = $urandom_range(1, 4);
      payload.delete();
      for (int i = 0; i < len; i++) payload.push_back(8'($urandom));
      run_frame(-1, 0);
    end

`ifdef IRDA_FIR_TX_CRC_EN
    payload = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    run_frame(-1, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
